// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-fetch sequencer with a 2-entry decode queue
module fetch_sequencer #(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         INST_WIDTH      = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       mem_req,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    input  logic                       mem_ack,
    input  logic [INST_WIDTH-1:0]      mem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       inst_valid,
    output logic [INST_WIDTH-1:0]      inst_data,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                     state, state_n;
    logic [INST_ADDR_WIDTH-1:0] pc, pc_n;
    logic [INST_ADDR_WIDTH-1:0] disc_addr, disc_addr_n;
    logic                       out_valid, out_valid_n;
    logic [INST_WIDTH-1:0]      out_data, out_data_n;
    logic [INST_ADDR_WIDTH-1:0] out_pc, out_pc_n;
    logic                       skid_valid, skid_valid_n;
    logic [INST_WIDTH-1:0]      skid_data, skid_data_n;
    logic [INST_ADDR_WIDTH-1:0] skid_pc, skid_pc_n;
    logic                       take;
    logic                       consume;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            disc_addr  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else begin
            pc         <= pc_n;
            disc_addr  <= disc_addr_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_pc     <= out_pc_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_pc    <= skid_pc_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        disc_addr_n  = disc_addr;
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        out_pc_n     = out_pc;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_pc_n    = skid_pc;
        mem_req      = 1'b0;
        mem_addr     = pc;
        take         = 1'b0;
        consume      = 1'b0;

        case (state)
            IDLE: begin
                state_n = FETCH;
            end

            FETCH: begin
                mem_req = !skid_valid;
                if (redirect) begin
                    out_valid_n  = 1'b0;
                    skid_valid_n = 1'b0;
                    pc_n         = redirect_pc;
                    // The pending read must still complete; remember its address to keep it stable.
                    if (mem_req && !mem_ack) begin
                        state_n     = DISCARD;
                        disc_addr_n = pc;
                    end
                end else begin
                    take    = mem_req && mem_ack;
                    consume = out_valid && !stall;
                    if (take) begin
                        pc_n = pc + INST_ADDR_WIDTH'(4);
                    end
                    if (consume) begin
                        if (skid_valid) begin
                            out_data_n   = skid_data;
                            out_pc_n     = skid_pc;
                            skid_valid_n = 1'b0;
                            if (take) begin
                                skid_valid_n = 1'b1;
                                skid_data_n  = mem_rdata;
                                skid_pc_n    = pc;
                            end
                        end else if (take) begin
                            out_data_n = mem_rdata;
                            out_pc_n   = pc;
                        end else begin
                            out_valid_n = 1'b0;
                        end
                    end else if (take) begin
                        if (!out_valid) begin
                            out_valid_n = 1'b1;
                            out_data_n  = mem_rdata;
                            out_pc_n    = pc;
                        end else begin
                            skid_valid_n = 1'b1;
                            skid_data_n  = mem_rdata;
                            skid_pc_n    = pc;
                        end
                    end
                end
            end

            DISCARD: begin
                mem_req  = 1'b1;
                mem_addr = disc_addr;
                if (redirect) begin
                    pc_n = redirect_pc;
                end
                if (mem_ack) begin
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign inst_valid = out_valid;
    assign inst_data  = out_data;
    assign inst_pc    = out_pc;

endmodule
